// File: rtl/imm_decode_pipe.sv
// Immediate decoder feeding an in-order output FIFO.
// Decode is combinational; decoded {imm, has_imm, illegal} entries are queued with one-cycle latency.
module imm_decode_pipe #(
  parameter int unsigned IMM_WIDTH = 32,
  parameter int unsigned SIGN_EXT  = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [IMM_WIDTH-1:0]   out_imm,
  output logic                   out_has_imm,
  output logic                   out_illegal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             illegal_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = IMM_WIDTH + 2;

  logic [3:0]           opcode;
  logic [IMM_WIDTH-1:0] dec_imm;
  logic                 dec_has;
  logic                 dec_illegal;

  assign opcode      = in_instr[31:28];
  assign dec_illegal = (opcode >= 4'd13);

  // Sized casts of signed slices sign-extend; a zero field stays zero in both modes.
  always_comb begin
    dec_imm = '0;
    dec_has = 1'b0;
    unique case (opcode)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        if (in_instr[0]) begin
          dec_has = 1'b1;
          dec_imm = (SIGN_EXT != 0) ? IMM_WIDTH'($signed(in_instr[15:1]))
                                    : IMM_WIDTH'(in_instr[15:1]);
        end
      end
      4'd6: begin
        if (!in_instr[1]) begin
          dec_has = 1'b1;
          dec_imm = (SIGN_EXT != 0) ? IMM_WIDTH'($signed(in_instr[27:2]))
                                    : IMM_WIDTH'(in_instr[27:2]);
        end
      end
      4'd8: begin
        dec_has = 1'b1;
        dec_imm = (SIGN_EXT != 0) ? IMM_WIDTH'($signed(in_instr[21:0]))
                                  : IMM_WIDTH'(in_instr[21:0]);
      end
      default: begin
        dec_imm = '0;
        dec_has = 1'b0;
      end
    endcase
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    illegal_cnt_q, illegal_cnt_d;
  logic          rdy_en_q;
  logic          push, pop;
  logic [EW-1:0] head;

  // rdy_en_q holds in_ready low through reset and releases it on the first edge afterwards.
  assign in_ready  = rdy_en_q & (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rptr_q];

  assign out_imm     = out_valid ? head[EW-1:2] : '0;
  assign out_has_imm = out_valid & head[1];
  assign out_illegal = out_valid & head[0];
  assign count       = count_q;
  assign illegal_cnt = illegal_cnt_q;

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) begin
      wptr_d = wptr_q + 1'b1;
      if (dec_illegal && illegal_cnt_q != 8'hFF) begin
        illegal_cnt_d = illegal_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
      rdy_en_q      <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
      rdy_en_q      <= 1'b1;
    end
  end

  // Storage needs no reset: outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= {dec_imm, dec_has, dec_illegal};
    end
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Randomized and directed bench for imm_decode_pipe; zero- and sign-extending instances share stimulus
// and are checked against a queue-based reference model.
module tb_imm_decode_pipe;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_has_imm, out_illegal, out_valid;
  logic [31:0] out_imm;
  logic [2:0]  count;
  logic [7:0]  illegal_cnt;

  logic        s_in_ready, s_out_has_imm, s_out_illegal, s_out_valid;
  logic [31:0] s_out_imm;
  logic [2:0]  s_count;
  logic [7:0]  s_illegal_cnt;

  imm_decode_pipe #(.IMM_WIDTH(32), .SIGN_EXT(0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .out_imm(out_imm), .out_has_imm(out_has_imm), .out_illegal(out_illegal),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .illegal_cnt(illegal_cnt)
  );

  imm_decode_pipe #(.IMM_WIDTH(32), .SIGN_EXT(1), .DEPTH(DEPTH)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_instr(in_instr), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_imm(s_out_imm), .out_has_imm(s_out_has_imm), .out_illegal(s_out_illegal),
    .out_valid(s_out_valid), .out_ready(out_ready), .count(s_count), .illegal_cnt(s_illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm_z;
    logic [31:0] imm_s;
    bit          has;
    bit          ill;
  } ent_t;

  ent_t q[$];
  bit   rdy_en_m = 1'b0;
  int   ill_m = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the field rules, extension done arithmetically.
  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t        e;
    int unsigned op;
    int unsigned width;
    longint      field;
    op    = w >> 28;
    width = 0;
    field = 0;
    e.has = 1'b0;
    if (op <= 3 && w[0]) begin
      width = 15; field = (w >> 1) % (1 << 15); e.has = 1'b1;
    end else if (op == 6 && (w % 4) < 2) begin
      width = 26; field = (w >> 2) % (1 << 26); e.has = 1'b1;
    end else if (op == 8) begin
      width = 22; field = w % (1 << 22); e.has = 1'b1;
    end
    e.imm_z = field[31:0];
    if (width != 0 && field >= (longint'(1) << (width - 1)))
      e.imm_s = 32'(field - (longint'(1) << width));
    else
      e.imm_s = field[31:0];
    e.ill = (op >= 13);
    return e;
  endfunction

  task automatic cycle();
    bit   rdy_m, push_m, pop_m;
    ent_t e;
    @(negedge clk);
    rdy_m = rdy_en_m && (q.size() != DEPTH);
    check_eq("in_ready", in_ready, rdy_m);
    check_eq("count", count, q.size());
    check_eq("out_valid", out_valid, q.size() != 0);
    check_eq("illegal_cnt", illegal_cnt, ill_m);
    check_eq("s_count", s_count, q.size());
    if (q.size() != 0) begin
      check_eq("head_imm", out_imm, q[0].imm_z);
      check_eq("head_imm_sext", s_out_imm, q[0].imm_s);
      check_eq("head_has", out_has_imm, q[0].has);
      check_eq("head_ill", out_illegal, q[0].ill);
    end else begin
      check_eq("idle_data", {out_imm, out_has_imm, out_illegal}, '0);
    end
    push_m = in_valid && rdy_m;
    pop_m  = (q.size() != 0) && out_ready;
    e      = ref_decode(in_instr);
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      rdy_en_m = 1'b0;
      ill_m    = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        q.push_back(e);
        if (e.ill && ill_m < 255) ill_m++;
      end
      rdy_en_m = 1'b1;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit r);
    in_valid  = v;
    in_instr  = w;
    out_ready = r;
    cycle();
  endtask

  function automatic logic [31:0] legal_word();
    logic [3:0] op;
    op = 4'($urandom_range(0, 12));
    return {op, 28'($urandom)};
  endfunction

  initial begin
    // Reset state
    drive(0, '0, 0);
    drive(0, '0, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_count", count, 0);
    rst_n = 1'b1;
    drive(0, '0, 1);
    check_eq("ready_after_rst", in_ready, 1);

    // SUM with bit0 set: 15-bit all-ones field
    drive(1, 32'h0000_FFFF, 1);
    check_eq("sum_zext", out_imm, 32'h0000_7FFF);
    check_eq("sum_sext", s_out_imm, 32'hFFFF_FFFF);
    check_eq("sum_has", out_has_imm, 1);

    // JUMP: [1:0]=00 carries an immediate, [1:0]=10 does not
    drive(1, 32'h6000_0004, 1);
    check_eq("jump_imm", out_imm, 32'h1);
    check_eq("jump_has", out_has_imm, 1);
    drive(1, 32'h6000_0006, 1);
    check_eq("jump10_imm", out_imm, 32'h0);
    check_eq("jump10_has", out_has_imm, 0);
    drive(1, 32'h6000_0002, 1);
    check_eq("jump10b_has", s_out_has_imm, 0);
    drive(1, 32'h8020_0000, 1);
    check_eq("write_sext", s_out_imm, 32'hFFE0_0000);
    drive(0, '0, 1);
    drive(0, '0, 1);

    // Fill and drain
    for (int i = 0; i < 5; i++) begin
      drive(1, legal_word(), 0);
      if (i == 3) begin
        check_eq("full_count", count, 4);
        check_eq("full_ready", in_ready, 0);
      end
    end
    check_eq("fifth_dropped", count, 4);
    for (int i = 0; i < 4; i++) drive(0, '0, 1);
    check_eq("drained", count, 0);

    // Simultaneous push/pop at count 2 and at full
    drive(1, legal_word(), 0);
    drive(1, legal_word(), 0);
    for (int i = 0; i < 6; i++) drive(1, legal_word(), 1);
    check_eq("pp_count2", count, 2);
    drive(0, '0, 1);
    drive(0, '0, 1);
    for (int i = 0; i < 4; i++) drive(1, legal_word(), 0);
    drive(1, legal_word(), 1);
    check_eq("pp_full_pop_only", count, 3);
    for (int i = 0; i < 3; i++) drive(0, '0, 1);

    // Illegal opcode saturation
    for (int i = 0; i < 300; i++) begin
      drive(1, {4'hF, 28'($urandom)}, 1);
      check_eq("ill_flag", out_illegal, 1);
    end
    drive(0, '0, 1);
    check_eq("ill_sat", illegal_cnt, 255);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0);
    end
    for (int i = 0; i < 5; i++) drive(0, '0, 1);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) drive(1, legal_word(), 0);
    check_eq("pre_rst_count", count, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", out_valid, 0);
    check_eq("async_count", count, 0);
    check_eq("async_ready", in_ready, 0);
    check_eq("async_ill", illegal_cnt, 0);
    q.delete();
    rdy_en_m = 1'b0;
    ill_m    = 0;
    drive(0, '0, 0);
    rst_n = 1'b1;
    drive(1, 32'h0000_0003, 1);
    drive(1, 32'h0000_0003, 1);
    check_eq("post_rst_latency", out_valid, 1);
    check_eq("post_rst_imm", out_imm, 32'h1);
    drive(0, '0, 1);
    drive(0, '0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
